// File: rtl/vigna_bus_arbiter.sv
// -----------------------------------------------------------------------------
// vigna_bus_arbiter
//
// Two-to-one memory-port arbiter placed directly downstream of the vigna core.
// The instruction-fetch port (i_*) and the data load/store port (d_*) are
// merged into one valid/ready memory port (m_*), so the core can attach to a
// single-port RAM or bus.
//
// The request toward memory is registered, and so is the response back toward
// the core. Read data stays stable after the ready pulse until the same side
// completes another transaction. Only one transaction is outstanding at a time.
//
// Parameters
//   ARB_MODE   : 0 = fixed priority (data wins a tie),
//                1 = round-robin (the side not granted last wins a tie)
//   ADDR_WIDTH : address width of every port
//
// Ports
//   clk      in   system clock, all state on the rising edge
//   reset    in   asynchronous, active-high reset
//   i_valid  in   fetch request, held until i_ready
//   i_ready  out  one-cycle completion pulse to the fetch side
//   i_addr   in   fetch address
//   i_rdata  out  fetched word, valid with i_ready, held until the next i_ready
//   d_valid  in   data request, held until d_ready
//   d_ready  out  one-cycle completion pulse to the data side
//   d_addr   in   data address
//   d_rdata  out  load word, valid with d_ready, held until the next d_ready
//   d_wdata  in   store data
//   d_wstrb  in   byte strobes, 0 = read
//   m_valid  out  memory request
//   m_ready  in   memory completion, sampled only while m_valid = 1
//   m_addr   out  memory address
//   m_rdata  in   memory read data, valid with m_ready
//   m_wdata  out  memory write data
//   m_wstrb  out  memory byte strobes
// -----------------------------------------------------------------------------
module vigna_bus_arbiter #(
    parameter int ARB_MODE   = 0,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_rdata,

    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic [31:0]           d_rdata,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wstrb,

    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [31:0]           m_rdata,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    state_t                  state,      state_next;
    grant_t                  last_grant, last_grant_next;
    grant_t                  winner,     winner_next;
    grant_t                  grant;

    logic                    m_valid_next;
    logic [ADDR_WIDTH-1:0]   m_addr_next;
    logic [31:0]             m_wdata_next;
    logic [3:0]              m_wstrb_next;
    logic                    i_ready_next;
    logic                    d_ready_next;
    logic [31:0]             i_rdata_next;
    logic [31:0]             d_rdata_next;

    // Tie-break between the two requesters. Only meaningful when at least one
    // side is valid; with a single requester that side always wins.
    function automatic grant_t pick_winner(input logic   iv,
                                           input logic   dv,
                                           input grant_t last);
        grant_t w;
        w = GRANT_DATA;
        if (iv && dv) begin
            if (ARB_MODE == 1) begin
                if (last == GRANT_DATA) begin
                    w = GRANT_INSTR;
                end else begin
                    w = GRANT_DATA;
                end
            end else begin
                w = GRANT_DATA;
            end
        end else if (iv) begin
            w = GRANT_INSTR;
        end else begin
            w = GRANT_DATA;
        end
        return w;
    endfunction

    assign grant = pick_winner(i_valid, d_valid, last_grant);

    // State and all registered outputs. Reset is asynchronous so the memory
    // request and both ready pulses drop immediately, even mid-transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_DATA;
            winner     <= GRANT_DATA;
            m_valid    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            winner     <= winner_next;
            m_valid    <= m_valid_next;
            m_addr     <= m_addr_next;
            m_wdata    <= m_wdata_next;
            m_wstrb    <= m_wstrb_next;
            i_ready    <= i_ready_next;
            d_ready    <= d_ready_next;
            i_rdata    <= i_rdata_next;
            d_rdata    <= d_rdata_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        winner_next     = winner;
        m_valid_next    = m_valid;
        m_addr_next     = m_addr;
        m_wdata_next    = m_wdata;
        m_wstrb_next    = m_wstrb;
        // Ready is a single-cycle pulse: it is only ever set on the BUSY->RESP
        // edge and falls back to zero on every other edge.
        i_ready_next    = 1'b0;
        d_ready_next    = 1'b0;
        i_rdata_next    = i_rdata;
        d_rdata_next    = d_rdata;

        case (state)
            IDLE: begin
                // Requester inputs are captured only here; later changes on
                // the core side cannot disturb the request in flight.
                if (i_valid || d_valid) begin
                    winner_next     = grant;
                    last_grant_next = grant;
                    m_valid_next    = 1'b1;
                    state_next      = BUSY;
                    if (grant == GRANT_DATA) begin
                        m_addr_next  = d_addr;
                        m_wdata_next = d_wdata;
                        m_wstrb_next = d_wstrb;
                    end else begin
                        m_addr_next  = i_addr;
                        m_wdata_next = '0;
                        m_wstrb_next = '0;
                    end
                end
            end

            BUSY: begin
                if (m_valid && m_ready) begin
                    // m_addr is left as-is; only the write payload is cleared.
                    m_valid_next = 1'b0;
                    m_wdata_next = '0;
                    m_wstrb_next = '0;
                    state_next   = RESP;
                    // Stores also capture m_rdata; the core ignores it.
                    if (winner == GRANT_DATA) begin
                        d_rdata_next = m_rdata;
                        d_ready_next = 1'b1;
                    end else begin
                        i_rdata_next = m_rdata;
                        i_ready_next = 1'b1;
                    end
                end
            end

            RESP: begin
                // The requester drops valid on this edge, so returning to IDLE
                // here cannot re-grant the request just completed.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
module tb_vigna_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;

    // Fixed-priority instance
    logic        i_ready0, d_ready0, m_valid0;
    logic [31:0] i_rdata0, d_rdata0, m_addr0, m_wdata0;
    logic [3:0]  m_wstrb0;
    // Round-robin instance
    logic        i_ready1, d_ready1, m_valid1;
    logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1;
    logic [3:0]  m_wstrb1;

    int checks;
    int failures;

    vigna_bus_arbiter #(.ARB_MODE(0), .ADDR_WIDTH(32)) dut0 (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready0), .i_addr(i_addr), .i_rdata(i_rdata0),
        .d_valid(d_valid), .d_ready(d_ready0), .d_addr(d_addr), .d_rdata(d_rdata0),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .m_valid(m_valid0), .m_ready(m_ready), .m_addr(m_addr0), .m_rdata(m_rdata),
        .m_wdata(m_wdata0), .m_wstrb(m_wstrb0)
    );

    vigna_bus_arbiter #(.ARB_MODE(1), .ADDR_WIDTH(32)) dut1 (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready1), .i_addr(i_addr), .i_rdata(i_rdata1),
        .d_valid(d_valid), .d_ready(d_ready1), .d_addr(d_addr), .d_rdata(d_rdata1),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .m_valid(m_valid1), .m_ready(m_ready), .m_addr(m_addr1), .m_rdata(m_rdata),
        .m_wdata(m_wdata1), .m_wstrb(m_wstrb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
        logic        mr;
        logic [31:0] md;
        logic        mv;
        logic [31:0] ma;
        logic [3:0]  ms;
        logic [31:0] mw;
        logic        ir;
        logic        dr;
        logic [31:0] ird;
        logic [31:0] drd;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic iv, input logic [31:0] ia,
                                input logic dv, input logic [31:0] da,
                                input logic [31:0] dw, input logic [3:0] ds,
                                input logic mr, input logic [31:0] md,
                                input logic mv, input logic [31:0] ma,
                                input logic [3:0] ms, input logic [31:0] mw,
                                input logic ir, input logic dr,
                                input logic [31:0] ird, input logic [31:0] drd);
        vec_t v;
        v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dw = dw; v.ds = ds;
        v.mr = mr; v.md = md; v.mv = mv; v.ma = ma; v.ms = ms; v.mw = mw;
        v.ir = ir; v.dr = dr; v.ird = ird; v.drd = drd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // The two ready pulses must never coincide on either instance.
    always @(negedge clk) begin
        checks++;
        if ((i_ready0 && d_ready0) || (i_ready1 && d_ready1)) begin
            failures++;
            $display("FAIL both_ready: dut0 i=%0b d=%0b dut1 i=%0b d=%0b required not both 1",
                     i_ready0, d_ready0, i_ready1, d_ready1);
        end
    end

    initial begin
        int n;
        logic [31:0] rr_exp [4];

        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        i_valid  = 1'b0; i_addr  = '0;
        d_valid  = 1'b0; d_addr  = '0; d_wdata = '0; d_wstrb = '0;
        m_ready  = 1'b0; m_rdata = '0;

        //           iv ia        dv da        dw            ds    mr md            mv ma        ms    mw            ir dr ird       drd
        vecs[0]  = mk(1,32'h100, 0,32'h0,    32'h0,        4'h0, 0,32'h0,        1,32'h100, 4'h0,32'h0,        0,0,32'h0,   32'h0);
        vecs[1]  = mk(1,32'h100, 0,32'h0,    32'h0,        4'h0, 1,32'h13,       0,32'h100, 4'h0,32'h0,        1,0,32'h13,  32'h0);
        vecs[2]  = mk(0,32'h0,   0,32'h0,    32'h0,        4'h0, 0,32'h0,        0,32'h100, 4'h0,32'h0,        0,0,32'h13,  32'h0);
        vecs[3]  = mk(0,32'h0,   0,32'h0,    32'h0,        4'h0, 1,32'h55,       0,32'h100, 4'h0,32'h0,        0,0,32'h13,  32'h0);
        vecs[4]  = mk(0,32'h0,   1,32'h2004, 32'hDEADBEEF, 4'hF, 0,32'h0,        1,32'h2004,4'hF,32'hDEADBEEF, 0,0,32'h13,  32'h0);
        vecs[5]  = mk(0,32'h0,   1,32'h3000, 32'h11111111, 4'h3, 0,32'h0,        1,32'h2004,4'hF,32'hDEADBEEF, 0,0,32'h13,  32'h0);
        vecs[6]  = mk(0,32'h0,   1,32'h3000, 32'h11111111, 4'h3, 0,32'h0,        1,32'h2004,4'hF,32'hDEADBEEF, 0,0,32'h13,  32'h0);
        vecs[7]  = mk(0,32'h0,   1,32'h2004, 32'hDEADBEEF, 4'hF, 0,32'h0,        1,32'h2004,4'hF,32'hDEADBEEF, 0,0,32'h13,  32'h0);
        vecs[8]  = mk(0,32'h0,   1,32'h2004, 32'hDEADBEEF, 4'hF, 1,32'hAAAA5555, 0,32'h2004,4'h0,32'h0,        0,1,32'h13,  32'hAAAA5555);
        vecs[9]  = mk(0,32'h0,   0,32'h0,    32'h0,        4'h0, 0,32'h0,        0,32'h2004,4'h0,32'h0,        0,0,32'h13,  32'hAAAA5555);
        vecs[10] = mk(1,32'h100, 1,32'h2000, 32'h0,        4'h0, 0,32'h0,        1,32'h2000,4'h0,32'h0,        0,0,32'h13,  32'hAAAA5555);
        vecs[11] = mk(1,32'h100, 1,32'h2000, 32'h0,        4'h0, 1,32'h12345678, 0,32'h2000,4'h0,32'h0,        0,1,32'h13,  32'h12345678);
        vecs[12] = mk(1,32'h100, 0,32'h0,    32'h0,        4'h0, 0,32'h0,        0,32'h2000,4'h0,32'h0,        0,0,32'h13,  32'h12345678);
        vecs[13] = mk(1,32'h100, 0,32'h0,    32'h0,        4'h0, 0,32'h0,        1,32'h100, 4'h0,32'h0,        0,0,32'h13,  32'h12345678);
        vecs[14] = mk(1,32'h100, 0,32'h0,    32'h0,        4'h0, 1,32'h93,       0,32'h100, 4'h0,32'h0,        1,0,32'h93,  32'h12345678);
        vecs[15] = mk(0,32'h0,   0,32'h0,    32'h0,        4'h0, 0,32'h0,        0,32'h100, 4'h0,32'h0,        0,0,32'h93,  32'h12345678);
        vecs[16] = mk(0,32'h0,   1,32'h40,   32'h0,        4'h0, 0,32'h0,        1,32'h40,  4'h0,32'h0,        0,0,32'h93,  32'h12345678);
        vecs[17] = mk(0,32'h0,   1,32'h40,   32'h0,        4'h0, 1,32'h80000000, 0,32'h40,  4'h0,32'h0,        0,1,32'h93,  32'h80000000);
        vecs[18] = mk(1,32'h104, 0,32'h0,    32'h0,        4'h0, 0,32'h0,        0,32'h40,  4'h0,32'h0,        0,0,32'h93,  32'h80000000);
        vecs[19] = mk(1,32'h104, 0,32'h0,    32'h0,        4'h0, 0,32'h0,        1,32'h104, 4'h0,32'h0,        0,0,32'h93,  32'h80000000);
        vecs[20] = mk(1,32'h104, 0,32'h0,    32'h0,        4'h0, 1,32'h297,      0,32'h104, 4'h0,32'h0,        1,0,32'h297, 32'h80000000);
        vecs[21] = mk(0,32'h0,   0,32'h0,    32'h0,        4'h0, 0,32'h0,        0,32'h104, 4'h0,32'h0,        0,0,32'h297, 32'h80000000);
        vecs[22] = mk(0,32'h0,   1,32'h50,   32'hCAFEF00D, 4'h3, 0,32'h0,        1,32'h50,  4'h3,32'hCAFEF00D, 0,0,32'h297, 32'h80000000);
        vecs[23] = mk(0,32'h0,   0,32'h0,    32'h0,        4'h0, 0,32'h0,        1,32'h50,  4'h3,32'hCAFEF00D, 0,0,32'h297, 32'h80000000);
        vecs[24] = mk(0,32'h0,   0,32'h0,    32'h0,        4'h0, 1,32'h77,       0,32'h50,  4'h0,32'h0,        0,1,32'h297, 32'h77);
        vecs[25] = mk(0,32'h0,   0,32'h0,    32'h0,        4'h0, 0,32'h0,        0,32'h50,  4'h0,32'h0,        0,0,32'h297, 32'h77);

        // Reset state of both instances
        #1 reset = 1'b1;
        #20;
        chk("rst0.m_valid", {31'b0, m_valid0}, 32'h0);
        chk("rst0.m_addr",  m_addr0,  32'h0);
        chk("rst0.m_wdata", m_wdata0, 32'h0);
        chk("rst0.m_wstrb", {28'b0, m_wstrb0}, 32'h0);
        chk("rst0.readies", {30'b0, i_ready0, d_ready0}, 32'h0);
        chk("rst0.i_rdata", i_rdata0, 32'h0);
        chk("rst0.d_rdata", d_rdata0, 32'h0);
        chk("rst1.outs",    {30'b0, m_valid1, i_ready1 | d_ready1}, 32'h0);
        chk("rst1.data",    m_addr1 | m_wdata1 | {28'b0, m_wstrb1} | i_rdata1 | d_rdata1, 32'h0);

        @(posedge clk);
        #1 reset = 1'b0;

        // Directed table on the fixed-priority instance
        for (int k = 0; k < NVEC; k++) begin
            i_valid = vecs[k].iv; i_addr  = vecs[k].ia;
            d_valid = vecs[k].dv; d_addr  = vecs[k].da;
            d_wdata = vecs[k].dw; d_wstrb = vecs[k].ds;
            m_ready = vecs[k].mr; m_rdata = vecs[k].md;
            tick();
            chk($sformatf("v%0d.m_valid", k), {31'b0, m_valid0}, {31'b0, vecs[k].mv});
            chk($sformatf("v%0d.m_addr",  k), m_addr0,  vecs[k].ma);
            chk($sformatf("v%0d.m_wstrb", k), {28'b0, m_wstrb0}, {28'b0, vecs[k].ms});
            chk($sformatf("v%0d.m_wdata", k), m_wdata0, vecs[k].mw);
            chk($sformatf("v%0d.i_ready", k), {31'b0, i_ready0}, {31'b0, vecs[k].ir});
            chk($sformatf("v%0d.d_ready", k), {31'b0, d_ready0}, {31'b0, vecs[k].dr});
            chk($sformatf("v%0d.i_rdata", k), i_rdata0, vecs[k].ird);
            chk($sformatf("v%0d.d_rdata", k), d_rdata0, vecs[k].drd);
        end

        // Round-robin: both sides requesting continuously, memory always ready
        i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
        #2 reset = 1'b1;
        tick();
        i_valid = 1'b1; i_addr = 32'h100;
        d_valid = 1'b1; d_addr = 32'h2000; d_wdata = '0; d_wstrb = '0;
        m_ready = 1'b1; m_rdata = 32'h0;
        reset = 1'b0;
        rr_exp[0] = 32'h100; rr_exp[1] = 32'h2000;
        rr_exp[2] = 32'h100; rr_exp[3] = 32'h2000;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!m_valid1 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("rr%0d.granted", g), {31'b0, m_valid1}, 32'h1);
            chk($sformatf("rr%0d.m_addr", g), m_addr1, rr_exp[g]);
            n = 0;
            while (m_valid1 && n < 20) begin
                tick();
                n++;
            end
        end
        i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
        tick(); tick(); tick();

        // Async reset in BUSY, off the clock edge
        d_valid = 1'b1; d_addr = 32'h60; d_wstrb = 4'h0;
        tick();
        chk("arst_busy.pre_m_valid", {31'b0, m_valid0}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy.m_valid", {31'b0, m_valid0}, 32'h0);
        chk("arst_busy.m_addr",  m_addr0, 32'h0);
        chk("arst_busy.readies", {30'b0, i_ready0, d_ready0}, 32'h0);
        d_valid = 1'b0;
        #3 reset = 1'b0;
        m_ready = 1'b1; m_rdata = 32'hFFFF0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("late_mready%0d.readies", c), {30'b0, i_ready0, d_ready0}, 32'h0);
            chk($sformatf("late_mready%0d.m_valid", c), {31'b0, m_valid0}, 32'h0);
            chk($sformatf("late_mready%0d.d_rdata", c), d_rdata0, 32'h0);
        end

        // Async reset during the RESP cycle drops the ready pulse at once
        m_ready = 1'b0;
        i_valid = 1'b1; i_addr = 32'h70;
        tick();
        m_ready = 1'b1; m_rdata = 32'h1234;
        tick();
        chk("arst_resp.pre_i_ready", {31'b0, i_ready0}, 32'h1);
        chk("arst_resp.pre_i_rdata", i_rdata0, 32'h1234);
        #2 reset = 1'b1;
        #1;
        chk("arst_resp.i_ready", {31'b0, i_ready0}, 32'h0);
        chk("arst_resp.i_rdata", i_rdata0, 32'h0);
        i_valid = 1'b0; m_ready = 1'b0;
        #3 reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
